// File: rtl/frame_scanout_controller_pkg.sv
// Shared constants and types for the frame scan-out path.
// Imported by the scan-out controller, its bus interface and line buffer.
package graphics_pkg;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int LINE_TOTAL     = 525;
  localparam int WORDS_PER_LINE = 160;
  localparam int PIX_PER_WORD   = 4;
  localparam int SRAM_AW        = 20;
  localparam int SRAM_DW        = 16;
  localparam int LB_DEPTH       = 2 * WORDS_PER_LINE;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    CAPTURE,
    YIELD
  } fetch_state_e;

  typedef struct packed {
    logic       sel;
    logic [7:0] word;
  } lb_idx_t;

  function automatic logic [SRAM_AW-1:0] fetch_addr(
    input logic       fsel,
    input logic [9:0] row,
    input logic [7:0] word
  );
    return {1'b0, fsel, row, word};
  endfunction

endpackage

// File: rtl/frame_scanout_controller_if.sv
// SRAM arbitration and read bus between the scan-out fetcher
// (master) and the SRAM/arbiter side (slave).
interface frame_scanout_controller_if;
  import graphics_pkg::*;

  logic               sram_grant;
  logic               sram_req;
  logic               sram_yield;
  logic [SRAM_AW-1:0] SRAM_ADDRESS;
  logic               SRAM_OE_N;
  logic [SRAM_DW-1:0] Data_from_SRAM;

  modport master (
    input  sram_grant,
    input  Data_from_SRAM,
    output sram_req,
    output sram_yield,
    output SRAM_ADDRESS,
    output SRAM_OE_N
  );

  modport slave (
    output sram_grant,
    output Data_from_SRAM,
    input  sram_req,
    input  sram_yield,
    input  SRAM_ADDRESS,
    input  SRAM_OE_N
  );

endinterface

// File: rtl/frame_scanout_controller_line_buffer_ram.sv
// Two-line ping-pong buffer, one write and one registered read port.
// Half 0 holds entries 0..159, half 1 entries 160..319.
module line_buffer_ram
  import graphics_pkg::*;
(
  input  logic               Clk,
  input  logic               we_i,
  input  lb_idx_t            widx_i,
  input  logic [SRAM_DW-1:0] wdata_i,
  input  lb_idx_t            ridx_i,
  output logic [SRAM_DW-1:0] rdata_o
);

  logic [SRAM_DW-1:0] mem_q [LB_DEPTH];

  function automatic logic [8:0] flat(input lb_idx_t i);
    return {1'b0, i.word} + (i.sel ? 9'(WORDS_PER_LINE) : 9'd0);
  endfunction

  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[flat(widx_i)] <= wdata_i;
    end
    rdata_o <= mem_q[flat(ridx_i)];
  end

endmodule

// File: rtl/frame_scanout_controller.sv
// Prefetches the next VGA row from SRAM into a ping-pong line buffer
// and scans the current row out as 4-bit palette indices.
module frame_scanout_controller
  import graphics_pkg::*;
(
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       even_frame,
  frame_scanout_controller_if.master sram,
  output logic [3:0]                 pixel_index,
  output logic                       fetch_busy,
  output logic                       underflow,
  input  logic                       underflow_clr
);

  localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_LINE - 1);
  localparam logic [9:0] LAST_LINE = 10'(LINE_TOTAL - 1);
  localparam logic [9:0] LAST_PREF = 10'(SCREEN_H - 2);

  fetch_state_e state_q, state_d;

  logic       pending_q, pending_d;
  logic [7:0] word_q, word_d;
  logic [9:0] row_q, row_d;
  logic       front_q, front_d;
  logic       fsel_q, fsel_d;
  logic       undf_q, undf_d;
  logic       xnz_q;
  logic       vis_q;
  logic [1:0] nib_q;

  logic               line_start;
  logic               start_fetch;
  logic               visible;
  logic               lb_we;
  logic               oe_n;
  logic               yield;
  logic [SRAM_AW-1:0] addr;
  logic [SRAM_DW-1:0] lb_rdata;
  lb_idx_t            widx;
  lb_idx_t            ridx;

  assign line_start  = (DrawX == '0) && xnz_q;
  assign start_fetch = (DrawY <= LAST_PREF) || (DrawY == LAST_LINE);
  assign visible     = (DrawX < 10'(SCREEN_W))
                    && (DrawY < 10'(SCREEN_H));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    word_d    = word_q;
    row_d     = row_q;
    lb_we     = 1'b0;
    oe_n      = 1'b1;
    yield     = 1'b0;
    addr      = '0;
    unique case (state_q)
      IDLE: begin
        yield = 1'b1;
        if (pending_q && sram.sram_grant) state_d = ADDR;
      end
      ADDR: begin
        oe_n    = 1'b0;
        addr    = fetch_addr(fsel_q, row_q, word_q);
        state_d = WAIT;
      end
      WAIT: begin
        oe_n    = 1'b0;
        addr    = fetch_addr(fsel_q, row_q, word_q);
        state_d = CAPTURE;
      end
      CAPTURE: begin
        oe_n  = 1'b0;
        addr  = fetch_addr(fsel_q, row_q, word_q);
        lb_we = 1'b1;
        if (word_q == LAST_WORD) begin
          pending_d = 1'b0;
          state_d   = IDLE;
        end else begin
          word_d  = word_q + 8'd1;
          state_d = YIELD;
        end
      end
      YIELD: begin
        yield = 1'b1;
        if (sram.sram_grant) state_d = ADDR;
      end
      default: state_d = IDLE;
    endcase
    // A new line aborts any unfinished fetch before the buffers swap.
    if (line_start) begin
      state_d   = IDLE;
      lb_we     = 1'b0;
      pending_d = start_fetch;
      word_d    = '0;
      if (start_fetch) begin
        row_d = (DrawY == LAST_LINE) ? '0 : DrawY + 10'd1;
      end
    end
  end

  always_comb begin
    front_d = front_q ^ line_start;
    fsel_d  = fsel_q;
    undf_d  = undf_q;
    if (line_start && (DrawY == LAST_LINE)) fsel_d = even_frame;
    if (underflow_clr) undf_d = 1'b0;
    if (line_start && pending_q) undf_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      word_q    <= '0;
      row_q     <= '0;
      front_q   <= 1'b0;
      fsel_q    <= 1'b0;
      undf_q    <= 1'b0;
      xnz_q     <= 1'b0;
      vis_q     <= 1'b0;
      nib_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      word_q    <= word_d;
      row_q     <= row_d;
      front_q   <= front_d;
      fsel_q    <= fsel_d;
      undf_q    <= undf_d;
      xnz_q     <= (DrawX != '0);
      vis_q     <= visible;
      nib_q     <= DrawX[1:0];
    end
  end

  // Read via front_d so the first Clk of a line already sees the new row.
  assign ridx.sel  = front_d;
  assign ridx.word = visible ? DrawX[9:2] : '0;
  assign widx.sel  = ~front_q;
  assign widx.word = word_q;

  line_buffer_ram u_lb (
    .Clk     (Clk),
    .we_i    (lb_we),
    .widx_i  (widx),
    .wdata_i (sram.Data_from_SRAM),
    .ridx_i  (ridx),
    .rdata_o (lb_rdata)
  );

  assign pixel_index = vis_q ? lb_rdata[{nib_q, 2'b00} +: 4] : 4'h0;

  assign sram.sram_req     = pending_q;
  assign sram.sram_yield   = yield;
  assign sram.SRAM_OE_N    = oe_n;
  assign sram.SRAM_ADDRESS = addr;
  assign fetch_busy        = pending_q;
  assign underflow         = undf_q;

endmodule

// File: tb/tb_frame_scanout_controller.sv
// Scoreboard bench: expected SRAM bursts and pixels are queued by the
// stimulus and popped by a monitor when the DUT presents them.
module tb_frame_scanout_controller;
  import graphics_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       even_frame = 1'b0;
  logic       underflow_clr = 1'b0;
  logic [3:0] pixel_index;
  logic       fetch_busy;
  logic       underflow;

  frame_scanout_controller_if bus ();

  frame_scanout_controller dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .even_frame    (even_frame),
    .sram          (bus.master),
    .pixel_index   (pixel_index),
    .fetch_busy    (fetch_busy),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  always #5 Clk = ~Clk;

  int          tests = 0;
  int          fails = 0;
  int          bursts = 0;
  logic        probe = 1'b0;
  logic [19:0] addr_q[$];
  logic [3:0]  pix_q[$];

  // Row 5 holds {4{k}}; other rows {row[3:0], k, B, 7}.
  function automatic logic [15:0] mem_word(input logic [19:0] a);
    logic [9:0] r = a[17:8];
    logic [3:0] k = a[3:0];
    if (r == 10'd5) return {4{k}};
    return {r[3:0], k, 4'hB, 4'h7};
  endfunction

  always_comb begin
    bus.Data_from_SRAM = bus.SRAM_OE_N ? 16'hDEAD
                                       : mem_word(bus.SRAM_ADDRESS);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic        prev_oe = 1'b1;
    logic        pix_due = 1'b0;
    logic [19:0] ea;
    logic [3:0]  ep;
    forever begin
      @(negedge Clk);
      if (bus.SRAM_OE_N === 1'b0) begin
        tests++;
        if (bus.sram_grant !== 1'b1) begin
          fails++;
          $display("FAIL oe_grant: grant %b with OE_N low, required 1",
                   bus.sram_grant);
        end
        if (prev_oe) begin
          bursts++;
          tests++;
          if (addr_q.size() == 0) begin
            fails++;
            $display("FAIL burst_addr: got %h, required no access",
                     bus.SRAM_ADDRESS);
          end else begin
            ea = addr_q.pop_front();
            if (bus.SRAM_ADDRESS !== ea) begin
              fails++;
              $display("FAIL burst_addr: got %h, required %h",
                       bus.SRAM_ADDRESS, ea);
            end
          end
        end
      end
      prev_oe = (bus.SRAM_OE_N !== 1'b0);
      if (pix_due) begin
        tests++;
        if (pix_q.size() == 0) begin
          fails++;
          $display("FAIL pixel: got %h, required nothing queued",
                   pixel_index);
        end else begin
          ep = pix_q.pop_front();
          if (pixel_index !== ep) begin
            fails++;
            $display("FAIL pixel: got %h, required %h at x=%0d y=%0d",
                     pixel_index, ep, DrawX, DrawY);
          end
        end
      end
      pix_due = probe;
    end
  endtask

  // frow < 0: no fetch expected on this line.
  task automatic do_line(input logic [9:0] y, input int frow,
                         input logic fsel);
    DrawX = 10'd700;
    tick();
    if (frow >= 0) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        addr_q.push_back({1'b0, fsel, 10'(frow), 8'(k)});
      end
    end
    DrawX = '0;
    DrawY = y;
    tick();
  endtask

  task automatic probe_px(input logic [9:0] x, input logic [9:0] y,
                          input logic [3:0] exp);
    DrawX = x;
    DrawY = y;
    pix_q.push_back(exp);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (fetch_busy && n < 3000) begin
      tick();
      n++;
    end
    chk({nm, "_done"}, 32'(fetch_busy), 32'd0);
    chk({nm, "_sb_empty"}, 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int b0;
    fork
      monitor();
    join_none

    bus.sram_grant = 1'b1;
    repeat (3) tick();
    chk("rst_oe_n", 32'(bus.SRAM_OE_N), 32'd1);
    chk("rst_addr", 32'(bus.SRAM_ADDRESS), 32'd0);
    chk("rst_req", 32'(bus.sram_req), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_undf", 32'(underflow), 32'd0);
    chk("rst_pix", 32'(pixel_index), 32'd0);
    Reset = 1'b0;
    tick();

    // Row 5 prefetch during line 4.
    b0 = bursts;
    do_line(10'd4, 5, 1'b0);
    chk("ls_busy", 32'(fetch_busy), 32'd1);
    chk("ls_req", 32'(bus.sram_req), 32'd1);
    n = 0;
    while (bus.SRAM_OE_N && n < 10) begin
      tick();
      n++;
    end
    chk("first_access", 32'(n), 32'd1);
    n = 0;
    while (fetch_busy && n < 2000) begin
      tick();
      n++;
    end
    chk("line_fetch_len", 32'(n), 32'd639);
    chk("bursts_160", 32'(bursts - b0), 32'd160);
    chk("row5_sb_empty", 32'(addr_q.size()), 32'd0);

    do_line(10'd5, 6, 1'b0);
    probe_px(10'd9, 10'd5, 4'h2);
    probe_px(10'd1, 10'd5, 4'h0);
    probe_px(10'd63, 10'd5, 4'hF);
    probe_px(10'd636, 10'd5, 4'hF);
    probe_px(10'd640, 10'd5, 4'h0);
    probe_px(10'd700, 10'd5, 4'h0);
    wait_idle("row6");

    do_line(10'd6, 7, 1'b0);
    probe_px(10'd8, 10'd6, 4'h7);
    probe_px(10'd9, 10'd6, 4'hB);
    probe_px(10'd10, 10'd6, 4'h2);
    probe_px(10'd11, 10'd6, 4'h6);
    probe_px(10'd82, 10'd6, 4'h4);
    probe_px(10'd639, 10'd6, 4'h6);
    probe_px(10'd9, 10'd479, 4'hB);
    probe_px(10'd9, 10'd480, 4'h0);
    wait_idle("row7");

    // Grant revoked for 50 Clk at every yield point.
    do_line(10'd10, 11, 1'b0);
    n = 0;
    while (fetch_busy && n < 20000) begin
      if (bus.sram_yield) begin
        bus.sram_grant = 1'b0;
        repeat (50) tick();
        n += 50;
        bus.sram_grant = 1'b1;
      end
      tick();
      n++;
    end
    chk("drop_done", 32'(fetch_busy), 32'd0);
    chk("drop_sb_empty", 32'(addr_q.size()), 32'd0);
    chk("drop_undf", 32'(underflow), 32'd0);
    do_line(10'd11, 12, 1'b0);
    probe_px(10'd9, 10'd11, 4'hB);
    probe_px(10'd10, 10'd11, 4'h2);
    probe_px(10'd11, 10'd11, 4'hB);
    probe_px(10'd638, 10'd11, 4'hF);
    wait_idle("row12");

    // Frame select latched at line 524 and held for the frame.
    even_frame = 1'b1;
    do_line(10'd524, 0, 1'b1);
    repeat (5) tick();
    even_frame = 1'b0;
    wait_idle("f1_row0");
    do_line(10'd0, 1, 1'b1);
    wait_idle("f1_row1");
    do_line(10'd478, 479, 1'b1);
    wait_idle("f1_row479");
    do_line(10'd479, -1, 1'b0);
    chk("y479_busy", 32'(fetch_busy), 32'd0);
    chk("y479_req", 32'(bus.sram_req), 32'd0);
    repeat (10) tick();
    do_line(10'd524, 0, 1'b0);
    wait_idle("f0_row0");

    // Starved fetch turns into underflow at the next line.
    bus.sram_grant = 1'b0;
    do_line(10'd20, -1, 1'b0);
    chk("starve_req", 32'(bus.sram_req), 32'd1);
    repeat (100) tick();
    chk("starve_oe", 32'(bus.SRAM_OE_N), 32'd1);
    chk("starve_undf0", 32'(underflow), 32'd0);
    do_line(10'd21, -1, 1'b0);
    chk("undf_set", 32'(underflow), 32'd1);
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("undf_clr", 32'(underflow), 32'd0);
    DrawX = 10'd700;
    tick();
    DrawX = '0;
    DrawY = 10'd22;
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("undf_set_wins", 32'(underflow), 32'd1);
    for (int k = 0; k < WORDS_PER_LINE; k++) begin
      addr_q.push_back({2'b00, 10'd23, 8'(k)});
    end
    bus.sram_grant = 1'b1;
    wait_idle("row23");
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("undf_clr2", 32'(underflow), 32'd0);

    // Reset while the first word of row 31 sits in WAIT.
    do_line(10'd30, -1, 1'b0);
    addr_q.push_back(20'h01F00);
    probe_px(10'd9, 10'd30, 4'hB);
    tick();
    chk("wait_oe", 32'(bus.SRAM_OE_N), 32'd0);
    Reset = 1'b1;
    tick();
    chk("mid_rst_oe", 32'(bus.SRAM_OE_N), 32'd1);
    chk("mid_rst_req", 32'(bus.sram_req), 32'd0);
    chk("mid_rst_pix", 32'(pixel_index), 32'd0);
    chk("mid_rst_addr", 32'(bus.SRAM_ADDRESS), 32'd0);
    repeat (2) tick();
    Reset = 1'b0;
    repeat (20) tick();
    chk("post_rst_sb", 32'(addr_q.size()), 32'd0);
    chk("post_rst_busy", 32'(fetch_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
